led_matrix_scroller: RTL and testbench



---
 rtl/led_matrix_scroller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_led_matrix_scroller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scroller.sv
// led_matrix_scroller: column-scans a ROWS x COLS LED matrix and scrolls a
// switch-selected message segment out of a writable column-pattern memory.
// Selection, descriptor and scroll changes are applied only at frame
// boundaries so a frame never mixes two positions or messages.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   sel           one-hot message select switches
//   mem_we/addr/wdata           pattern memory write port (one column)
//   desc_we/idx/start/end/dir   descriptor write port (idx NUM_MSG = error slot)
//   row_out       row drive for the displayed column
//   col_out       one-hot column enable, column 0 on the MSB
//   active_msg    applied slot, NUM_MSG+1 = blank
//   sel_error     applied selection is multi-hot
module led_matrix_scroller #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int NUM_MSG    = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int SCAN_DIV   = 10000,
  parameter int SCROLL_DIV = 200000,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int IW = $clog2(NUM_MSG + 1),
  localparam int SW = $clog2(NUM_MSG + 2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_MSG-1:0] sel,
  input  logic               mem_we,
  input  logic [AW-1:0]      mem_addr,
  input  logic [ROWS-1:0]    mem_wdata,
  input  logic               desc_we,
  input  logic [IW-1:0]      desc_idx,
  input  logic [AW-1:0]      desc_start,
  input  logic [AW-1:0]      desc_end,
  input  logic               desc_dir,
  output logic [ROWS-1:0]    row_out,
  output logic [COLS-1:0]    col_out,
  output logic [SW-1:0]      active_msg,
  output logic               sel_error
);

  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);

  localparam logic [SW-1:0] BLANK = SW'(NUM_MSG + 1);
  localparam logic [SW-1:0] ERR   = SW'(NUM_MSG);

  // ---------------- prescalers ----------------
  logic [SCAN_W-1:0]   scan_cnt;
  logic                scan_tick;
  logic [SCROLL_W-1:0] scroll_cnt;
  logic                scroll_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
      scan_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_cnt  <= '0;
      scroll_tick <= 1'b0;
    end else if (scroll_cnt == SCROLL_W'(SCROLL_DIV - 1)) begin
      scroll_cnt  <= '0;
      scroll_tick <= 1'b1;
    end else begin
      scroll_cnt  <= scroll_cnt + SCROLL_W'(1);
      scroll_tick <= 1'b0;
    end
  end

  // ---------------- selection decode ----------------
  logic [NUM_MSG-1:0] sel_q;
  logic [SW-1:0]      dec_slot;

  always_ff @(posedge clk) begin
    if (reset) sel_q <= '0;
    else       sel_q <= sel;
  end

  always_comb begin
    dec_slot = BLANK;
    if (sel_q == '0) begin
      dec_slot = BLANK;
    end else if ((sel_q & (sel_q - NUM_MSG'(1))) != '0) begin
      dec_slot = ERR;
    end else begin
      for (int unsigned k = 0; k < NUM_MSG; k++) begin
        if (sel_q[k]) dec_slot = SW'(k);
      end
    end
  end

  // ---------------- descriptor table ----------------
  logic [AW-1:0]  d_start [NUM_MSG+1];
  logic [AW-1:0]  d_end   [NUM_MSG+1];
  logic           d_dir   [NUM_MSG+1];
  logic [NUM_MSG:0] desc_dirty;
  logic           desc_ok;
  logic           frame_edge;

  assign desc_ok = desc_we && (32'(desc_idx) <= 32'(NUM_MSG));

  // A written slot is flagged dirty; if it is the slot applied at the next
  // boundary it is reloaded exactly like a selection change.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= NUM_MSG; i++) begin
        d_start[i] <= '0;
        d_end[i]   <= '0;
        d_dir[i]   <= 1'b0;
      end
      desc_dirty <= '0;
    end else begin
      if (frame_edge) desc_dirty <= '0;
      if (desc_ok) begin
        d_start[desc_idx]    <= desc_start;
        d_end[desc_idx]      <= desc_end;
        d_dir[desc_idx]      <= desc_dir;
        desc_dirty[desc_idx] <= 1'b1;
      end
    end
  end

  // ---------------- pattern memory ----------------
  logic [ROWS-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // ---------------- scan / scroll state ----------------
  logic [CW-1:0] c;
  logic [AW-1:0] pos;
  logic [AW-1:0] rd_ptr;
  logic          pending;
  logic [AW-1:0] act_start;
  logic [AW-1:0] act_end;
  logic          act_dir;
  logic [AW-1:0] addr_q;
  logic          blank_q;
  logic [CW-1:0] col_q;

  logic [IW-1:0] new_idx;
  logic          new_is_blank;
  logic          reload;
  logic [AW-1:0] new_start;
  logic [AW-1:0] new_end;
  logic          new_dir;
  logic          invalid;
  logic          row_blank;
  logic [AW-1:0] next_rd;
  logic [AW-1:0] step_pos;

  assign frame_edge   = scan_tick && (c == CW'(COLS - 1));
  assign new_idx      = IW'(dec_slot);
  assign new_is_blank = (dec_slot == BLANK);
  assign reload       = (dec_slot != active_msg) ||
                        (!new_is_blank && desc_dirty[new_idx]);
  assign new_start    = new_is_blank ? '0   : d_start[new_idx];
  assign new_end      = new_is_blank ? '0   : d_end[new_idx];
  assign new_dir      = new_is_blank ? 1'b0 : d_dir[new_idx];
  assign invalid      = (act_end < act_start);
  assign row_blank    = (active_msg == BLANK) || invalid;

  always_comb begin
    next_rd = pos;
    if (c != '0) begin
      next_rd = (rd_ptr == act_end) ? act_start : rd_ptr + AW'(1);
    end
  end

  // A scroll_tick coinciding with the boundary counts as pending.
  always_comb begin
    step_pos = pos;
    if (invalid) begin
      step_pos = act_start;
    end else if (pending || scroll_tick) begin
      if (!act_dir) step_pos = (pos == act_end)   ? act_start : pos + AW'(1);
      else          step_pos = (pos == act_start) ? act_end   : pos - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c          <= '0;
      pos        <= '0;
      rd_ptr     <= '0;
      pending    <= 1'b0;
      active_msg <= BLANK;
      sel_error  <= 1'b0;
      act_start  <= '0;
      act_end    <= '0;
      act_dir    <= 1'b0;
      addr_q     <= '0;
      blank_q    <= 1'b1;
      col_q      <= '0;
    end else begin
      if (scan_tick) begin
        addr_q  <= next_rd;
        rd_ptr  <= next_rd;
        blank_q <= row_blank;
        col_q   <= c;
      end
      if (frame_edge) begin
        c       <= '0;
        pending <= 1'b0;
        if (reload) begin
          active_msg <= dec_slot;
          sel_error  <= (dec_slot == ERR);
          act_start  <= new_start;
          act_end    <= new_end;
          act_dir    <= new_dir;
          pos        <= new_start;
        end else begin
          pos <= step_pos;
        end
      end else begin
        if (scan_tick)   c       <= c + CW'(1);
        if (scroll_tick) pending <= 1'b1;
      end
    end
  end

  // ---------------- output stage ----------------
  logic            fetch;
  logic [COLS-1:0] col_onehot;

  always_comb begin
    col_onehot = '0;
    for (int unsigned k = 0; k < COLS; k++) begin
      col_onehot[k] = (col_q == CW'(COLS - 1 - k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch   <= 1'b0;
      row_out <= '0;
      col_out <= '0;
    end else begin
      fetch <= scan_tick;
      if (fetch) begin
        row_out <= blank_q ? '0 : mem[addr_q];
        col_out <= col_onehot;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scroller.sv
// Directed bench for led_matrix_scroller with small parameters.
module tb_led_matrix_scroller;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int NUM_MSG    = 4;
  localparam int MEM_DEPTH  = 16;
  localparam int SCAN_DIV   = 2;
  localparam int SCROLL_DIV = 32;
  localparam int AW = 4;
  localparam int IW = 3;
  localparam int SW = 3;

  logic               clk;
  logic               reset;
  logic [NUM_MSG-1:0] sel;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [ROWS-1:0]    mem_wdata;
  logic               desc_we;
  logic [IW-1:0]      desc_idx;
  logic [AW-1:0]      desc_start;
  logic [AW-1:0]      desc_end;
  logic               desc_dir;
  logic [ROWS-1:0]    row_out;
  logic [COLS-1:0]    col_out;
  logic [SW-1:0]      active_msg;
  logic               sel_error;

  led_matrix_scroller #(
    .ROWS(ROWS), .COLS(COLS), .NUM_MSG(NUM_MSG), .MEM_DEPTH(MEM_DEPTH),
    .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .desc_we(desc_we), .desc_idx(desc_idx), .desc_start(desc_start),
    .desc_end(desc_end), .desc_dir(desc_dir),
    .row_out(row_out), .col_out(col_out),
    .active_msg(active_msg), .sel_error(sel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [COLS-1:0] last_col;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_write(input logic [AW-1:0] a, input logic [ROWS-1:0] d);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic desc_write(input logic [IW-1:0] idx, input logic [AW-1:0] s,
                            input logic [AW-1:0] e, input logic dir);
    @(negedge clk);
    desc_we = 1'b1; desc_idx = idx; desc_start = s; desc_end = e; desc_dir = dir;
    @(negedge clk);
    desc_we = 1'b0;
  endtask

  // Next change of col_out, sampled at the falling edge.
  task automatic wait_update(output logic [COLS-1:0] col, output logic [ROWS-1:0] row);
    bit found = 1'b0;
    col = '0; row = '0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (col_out != last_col) begin
        last_col = col_out;
        col = col_out;
        row = row_out;
        found = 1'b1;
      end
    end
    if (!found) check("update_timeout", 32'(found), 1);
  endtask

  task automatic capture_frame(input string tag, input bit chk_cols, output logic [15:0] frame);
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    int guard = 0;
    frame = '0;
    do begin
      wait_update(col, row);
      guard++;
    end while (col != 4'b1000 && guard < 8);
    if (chk_cols) check({tag, "_col0"}, col, 4'b1000);
    frame[15:12] = row;
    for (int i = 1; i < 4; i++) begin
      wait_update(col, row);
      frame[15-4*i -: 4] = row;
      if (chk_cols) check($sformatf("%s_col%0d", tag, i), col, 32'(4'b1000 >> i));
    end
  endtask

  task automatic wait_active(input string tag, input logic [SW-1:0] target);
    for (int n = 0; n < 100 && active_msg != target; n++) @(negedge clk);
    check(tag, active_msg, target);
  endtask

  // Capture frames until the content moves off prev, then compare.
  task automatic scroll_to(input string tag, input logic [15:0] prev,
                           input logic [15:0] exp, output logic [15:0] frame);
    frame = prev;
    for (int n = 0; n < 8 && frame == prev; n++) capture_frame(tag, 1'b0, frame);
    check(tag, frame, exp);
  endtask

  logic [15:0] f;
  logic [15:0] fwd_exp [6];
  logic [COLS-1:0] ucol;
  logic [ROWS-1:0] urow;
  int lat;

  initial begin
    fwd_exp = '{16'h2345, 16'h3456, 16'h4561, 16'h5612, 16'h6123, 16'h1234};
    reset = 1'b1; sel = '0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    desc_we = 1'b0; desc_idx = '0; desc_start = '0; desc_end = '0; desc_dir = 1'b0;
    last_col = '0;
    repeat (3) @(negedge clk);
    check("rst_row", row_out, 0);
    check("rst_col", col_out, 0);
    check("rst_active", active_msg, 5);
    check("rst_err", sel_error, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) mem_write(AW'(i), ROWS'(i + 1));
    mem_write(4'd8, 4'hA);
    mem_write(4'd9, 4'h5);
    mem_write(4'd12, 4'hF);
    desc_write(3'd0, 4'd0, 4'd5, 1'b0);
    desc_write(3'd1, 4'd0, 4'd5, 1'b1);
    desc_write(3'd2, 4'd8, 4'd9, 1'b0);
    desc_write(3'd3, 4'd12, 4'd12, 1'b0);
    desc_write(3'd4, 4'd12, 4'd12, 1'b0);

    // forward scroll
    sel = 4'b0001;
    wait_active("fwd_active", 3'd0);
    capture_frame("fwd_f1", 1'b1, f);
    check("fwd_f1", f, 16'h1234);
    for (int i = 0; i < 6; i++) scroll_to($sformatf("fwd_p%0d", i + 1), f, fwd_exp[i], f);

    // reverse scroll
    sel = 4'b0010;
    wait_active("rev_active", 3'd1);
    capture_frame("rev_f1", 1'b0, f);
    check("rev_f1", f, 16'h1234);
    scroll_to("rev_p5", f, 16'h6123, f);
    scroll_to("rev_p4", f, 16'h5612, f);

    // short segment wraps inside one frame
    sel = 4'b0100;
    wait_active("short_active", 3'd2);
    capture_frame("short_f1", 1'b0, f);
    check("short_f1", f, 16'hA5A5);
    scroll_to("short_p9", f, 16'h5A5A, f);

    // multi-hot and blank
    sel = 4'b0011;
    wait_active("multi_active", 3'd4);
    check("multi_err", sel_error, 1);
    capture_frame("multi_f", 1'b0, f);
    check("multi_f", f, 16'hFFFF);
    sel = 4'b0000;
    wait_active("blank_active", 3'd5);
    check("blank_err", sel_error, 0);
    capture_frame("blank_f", 1'b0, f);
    check("blank_f", f, 16'h0000);

    // mid-frame selection change
    sel = 4'b1000;
    wait_active("mid_active", 3'd3);
    capture_frame("mid_f0", 1'b0, f);
    check("mid_f0", f, 16'hFFFF);
    for (int n = 0; n < 8; n++) begin
      wait_update(ucol, urow);
      if (ucol == 4'b0100) break;
    end
    sel = 4'b0001;
    wait_update(ucol, urow);
    check("mid_c2_col", ucol, 4'b0010);
    check("mid_c2_row", urow, 4'hF);
    wait_update(ucol, urow);
    check("mid_c3_col", ucol, 4'b0001);
    check("mid_c3_row", urow, 4'hF);
    capture_frame("mid_new", 1'b0, f);
    check("mid_new", f, 16'h1234);
    check("mid_new_active", active_msg, 0);

    // reset while scrolled to pos 3
    scroll_to("pre_p1", f, 16'h2345, f);
    scroll_to("pre_p2", f, 16'h3456, f);
    scroll_to("pre_p3", f, 16'h4561, f);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_row", row_out, 0);
    check("mrst_col", col_out, 0);
    check("mrst_active", active_msg, 5);
    check("mrst_err", sel_error, 0);
    reset = 1'b0;
    last_col = '0;
    lat = 0;
    while (col_out == '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mrst_latency", 32'(lat), SCAN_DIV + 2);
    check("mrst_first_col", col_out, 4'b1000);
    check("mrst_first_row", row_out, 0);
    last_col = col_out;
    desc_write(3'd0, 4'd0, 4'd5, 1'b0);
    wait_active("mrst_active0", 3'd0);
    capture_frame("mem_retained", 1'b0, f);
    check("mem_retained", f, 16'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
